// File: rtl/fifo_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_pkg
// Description : Shared defaults and the buffer-entry type for fifo_rd_stream.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_stream_pkg;

    localparam int c_DATA_WIDTH     = 8;
    localparam int c_BURST_LEN      = 4;
    // Widest word an entry can carry; narrower words are zero-extended.
    localparam int c_ENTRY_DATA_MAX = 64;

    typedef struct packed {
        logic [c_ENTRY_DATA_MAX-1:0] data;
        logic                        parity;
    } buf_entry_t;

endpackage
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid_buf
// Description : Two-entry in-order valid/ready buffer with synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buf
    import fifo_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_flush,
    input  logic       i_valid,
    output logic       o_ready,
    input  buf_entry_t i_data,
    output logic       o_valid,
    input  logic       i_ready,
    output buf_entry_t o_data,
    output logic [1:0] o_occ
);

    buf_entry_t r_head;
    buf_entry_t r_tail;
    logic [1:0] r_occ;
    logic       w_push;
    logic       w_pop;

    assign o_valid = (r_occ != 2'd0);
    assign w_pop   = o_valid && i_ready;
    assign o_ready = (r_occ != 2'd2) || w_pop;
    assign w_push  = i_valid && o_ready;
    assign o_data  = r_head;
    assign o_occ   = r_occ;

    // r_head is always the oldest word, so the output only moves on a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else if (i_flush) begin
            r_occ <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Pops a latency-1 fifo into a framed valid/ready stream.
//               Optional macro FIFO_RD_STREAM_PARITY_EN adds m_parity.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int BURST_LEN  = c_BURST_LEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
    input  logic                         fifo_empty,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         m_last,
`ifdef FIFO_RD_STREAM_PARITY_EN
    output logic                         m_parity,
`endif
    input  logic                         flush,
    output logic [$clog2(BURST_LEN)-1:0] beat_cnt
);

    localparam int                 c_CNT_W     = $clog2(BURST_LEN);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(BURST_LEN - 1);

    logic               r_infl;
    logic [c_CNT_W-1:0] r_beat;
    logic [1:0]         w_occ;
    logic [2:0]         w_level;
    logic               w_pop;
    logic               w_skid_ready;
    buf_entry_t         w_in_entry;
    buf_entry_t         w_out_entry;
    logic               w_unused_sink;

    assign w_pop = m_valid && m_ready;

    // Words already owned (buffered + in flight) minus the one leaving now.
    assign w_level    = {1'b0, w_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    assign fifo_rd_en = rst_n && !fifo_empty && !flush && (w_level < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_infl <= 1'b0;
        end else begin
            r_infl <= fifo_rd_en;
        end
    end

    always_comb begin
        w_in_entry      = '0;
        w_in_entry.data = c_ENTRY_DATA_MAX'(fifo_rd_data);
`ifdef FIFO_RD_STREAM_PARITY_EN
        w_in_entry.parity = ^fifo_rd_data;
`else
        w_in_entry.parity = 1'b0;
`endif
    end

    stream_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_valid (r_infl && !flush),
        .o_ready (w_skid_ready),
        .i_data  (w_in_entry),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_data  (w_out_entry),
        .o_occ   (w_occ)
    );

    assign m_data = w_out_entry.data[DATA_WIDTH-1:0];
`ifdef FIFO_RD_STREAM_PARITY_EN
    assign m_parity = w_out_entry.parity;
`endif

    // A pop on the flush edge is still delivered, but the frame restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if (flush) begin
            r_beat <= '0;
        end else if (w_pop) begin
            r_beat <= (r_beat == c_LAST_BEAT) ? '0 : r_beat + c_CNT_W'(1);
        end
    end

    assign beat_cnt = r_beat;
    assign m_last   = m_valid && (r_beat == c_LAST_BEAT);

    // Read-issue logic guarantees room, so the buffer's ready is not needed.
    assign w_unused_sink = ^{w_skid_ready, w_out_entry.data, w_out_entry.parity};

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Randomised and directed self-checking bench for fifo_rd_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = $clog2(BL);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_empty;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          flush = 1'b0;
    logic [CW-1:0] beat_cnt;
`ifdef FIFO_RD_STREAM_PARITY_EN
    logic          m_parity;
`endif

    fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
`ifdef FIFO_RD_STREAM_PARITY_EN
        .m_parity     (m_parity),
`endif
        .flush        (flush),
        .beat_cnt     (beat_cnt)
    );

    always #5 clk = ~clk;

    // Upstream fifo: latency-1 read port over a simple array.
    logic [DW-1:0] fifo_mem [0:4095];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rst_n && fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_rd_data <= fifo_mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        fifo_mem[wr_ptr] = d;
        wr_ptr++;
    endtask

    // Reference model: words captured and not yet accepted, plus the word in flight.
    logic [DW-1:0] exp_q[$];
    bit            infl_v = 1'b0;
    logic [DW-1:0] infl_d = '0;
    int            beat = 0;
    int            cyc = 0;

    logic [DW-1:0] acc_d[$];
    bit            acc_l[$];
    int            acc_c[$];
    int            rd_pulses = 0;
    int            first_rd = -1;
    int            first_val = -1;

    always @(negedge clk) begin
        #4;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            infl_v = 1'b0;
            beat   = 0;
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_beat_cnt", beat_cnt, 0);
            chk("rst_m_data", m_data, 0);
        end else begin
            bit ev;
            bit pop;
            bit erd;
            int lvl;
            ev  = (exp_q.size() != 0);
            pop = ev && m_ready;
            lvl = exp_q.size() + (infl_v ? 1 : 0) - (pop ? 1 : 0);
            erd = !fifo_empty && !flush && (lvl < 2);
            chk("m_valid", m_valid, ev);
            if (ev) begin
                chk("m_data", m_data, exp_q[0]);
`ifdef FIFO_RD_STREAM_PARITY_EN
                chk("m_parity", m_parity, ^exp_q[0]);
`endif
            end
            chk("m_last", m_last, ev && (beat == BL - 1));
            chk("beat_cnt", beat_cnt, beat);
            chk("fifo_rd_en", fifo_rd_en, erd);
            if (fifo_empty) chk("rd_while_empty", fifo_rd_en, 0);
            if (fifo_rd_en) begin
                rd_pulses++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (m_valid && first_val < 0) first_val = cyc;
            if (pop) begin
                acc_d.push_back(m_data);
                acc_l.push_back(m_last);
                acc_c.push_back(cyc);
                void'(exp_q.pop_front());
                beat = (beat + 1) % BL;
            end
            if (flush) begin
                exp_q.delete();
                beat = 0;
            end else if (infl_v) begin
                exp_q.push_back(infl_d);
            end
            infl_v = fifo_rd_en && !fifo_empty;
            infl_d = fifo_mem[rd_ptr];
        end
    end

    task automatic clear_log();
        acc_d.delete();
        acc_l.delete();
        acc_c.delete();
        rd_pulses = 0;
        first_rd  = -1;
        first_val = -1;
    endtask

    task automatic wait_acc(input int n, input string name);
        int budget;
        budget = 400;
        while (acc_d.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (acc_d.size() < n) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d beats, required %0d", name, acc_d.size(), n);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 3000;
        flush   = 1'b0;
        m_ready = 1'b1;
        while (!(fifo_empty && !m_valid && !infl_v) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got m_valid=%0b fifo_empty=%0b, required idle", m_valid, fifo_empty);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n1;
        logic [DW-1:0] nxt;

        // Reset with a preloaded fifo: reads must be held off.
        for (int i = 0; i < 8; i++) push(DW'(i));
        repeat (3) @(negedge clk);
        chk("reset_valid", m_valid, 0);
        chk("reset_rd_en", fifo_rd_en, 0);
        chk("reset_beat", beat_cnt, 0);

        // Full-rate streaming of 0x00..0x07.
        clear_log();
        m_ready = 1'b1;
        rst_n   = 1'b1;
        wait_acc(8, "s2");
        chk("s2_latency", first_val - first_rd, 2);
        for (int i = 0; i < 8 && i < acc_d.size(); i++) begin
            chk("s2_data", acc_d[i], i);
            chk("s2_last", acc_l[i], (i % 4) == 3);
            if (i > 0) chk("s2_no_bubble", acc_c[i] - acc_c[i-1], 1);
        end

        // Back-pressure: at most two reads, head word held.
        repeat (3) @(negedge clk);
        clear_log();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(DW'(8'h10 + i));
        repeat (10) @(negedge clk);
        chk("s3_rd_pulses", rd_pulses, 2);
        chk("s3_hold_valid", m_valid, 1);
        chk("s3_hold_data", m_data, 8'h10);
        m_ready = 1'b1;
        wait_acc(16, "s3");
        for (int i = 0; i < 16 && i < acc_d.size(); i++) chk("s3_data", acc_d[i], 8'h10 + i);

        // Alternating ready over 16 words.
        repeat (3) @(negedge clk);
        clear_log();
        for (int i = 0; i < 16; i++) push(DW'(8'h20 + i));
        begin
            int budget;
            budget = 200;
            while (acc_d.size() < 16 && budget > 0) begin
                m_ready = ~m_ready;
                @(negedge clk);
                budget--;
            end
        end
        wait_acc(16, "s4");
        for (int i = 0; i < 16 && i < acc_d.size(); i++) begin
            chk("s4_data", acc_d[i], 8'h20 + i);
            chk("s4_last", acc_l[i], (i % 4) == 3);
        end

        // Flush while streaming: the pop on the flush edge still counts.
        clear_log();
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) push(DW'(8'h30 + i));
        for (int i = 0; i < 8; i++) push(DW'(8'h40 + i));
        wait_acc(3, "s5a_pre");
        flush = 1'b1;
        nxt   = fifo_mem[rd_ptr];
        @(negedge clk);
        flush = 1'b0;
        chk("s5a_valid_after_flush", m_valid, 0);
        chk("s5a_beat_after_flush", beat_cnt, 0);
        chk("s5a_flush_pop_counted", acc_d.size(), 4);
        n1 = acc_d.size();
        wait_acc(n1 + 1, "s5a");
        if (acc_d.size() > n1) chk("s5a_next_word", acc_d[n1], nxt);

        // Flush with a full buffer under back-pressure.
        m_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("s5b_full_valid", m_valid, 1);
        flush = 1'b1;
        nxt   = fifo_mem[rd_ptr];
        @(negedge clk);
        flush = 1'b0;
        chk("s5b_valid_after_flush", m_valid, 0);
        chk("s5b_beat_after_flush", beat_cnt, 0);
        m_ready = 1'b1;
        n1 = acc_d.size();
        wait_acc(n1 + 1, "s5b");
        if (acc_d.size() > n1) chk("s5b_next_word", acc_d[n1], nxt);
        drain();

`ifdef FIFO_RD_STREAM_PARITY_EN
        m_ready = 1'b0;
        push(8'hAB);
        push(8'h03);
        repeat (4) @(negedge clk);
        chk("par_data_ab", m_data, 8'hAB);
        chk("par_ab", m_parity, 1);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("par_data_03", m_data, 8'h03);
        chk("par_03", m_parity, 0);
        drain();
`endif

        // Randomised traffic with occasional flushes and one mid-stream reset.
        for (int c = 0; c < 1500; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 1) == 1 && wr_ptr < 4000) push(DW'($urandom));
            if (c == 700) begin
                #2 rst_n = 1'b0;
            end
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

endmodule
`default_nettype wire
